// File: rtl/loba_prod_accumulator.sv
// Dot-product accumulator for LOBA multiplier products, with valid/ready on both sides.
// Optional build macro LOBA_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module loba_prod_accumulator #(
    parameter int PW    = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             out_hs;
    logic             collecting;
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             ovf_base;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

    function automatic logic [ACC_W-1:0] acc_limit(input logic [ACC_W-1:0] raw,
                                                   input logic             wrapped,
                                                   input logic             prior_ovf);
`ifdef LOBA_ACC_SAT_EN
        // Once pinned at all-ones the sum stays there for the rest of the group.
        return (wrapped | prior_ovf) ? '1 : raw;
`else
        return raw;
`endif
    endfunction

    assign collecting = (state == ACC);
    assign in_ready   = collecting | ((state == DONE) & out_ready);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid & in_ready;
    assign out_hs     = out_valid & out_ready;

    // A beat taken in DONE starts a fresh group while the old result leaves.
    assign acc_base = collecting ? acc : '0;
    assign cnt_base = collecting ? cnt : '0;
    assign ovf_base = collecting ? ovf : 1'b0;

    assign sum      = {1'b0, acc_base} + {{(ACC_W + 1 - PW){1'b0}}, in_prod};
    assign carry    = sum[ACC_W];
    assign acc_next = acc_limit(sum[ACC_W-1:0], carry, ovf_base);
    assign cnt_next = sat_inc(cnt_base);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_base | carry;
            state <= in_last ? DONE : ACC;
        end else if (out_hs) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end
    end

    assign out_acc = acc;
    assign out_cnt = cnt;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_loba_prod_accumulator.sv
// Scoreboard bench for loba_prod_accumulator (ACC_W=32 build so the wrap/saturate case is reachable).
module tb_loba_prod_accumulator;

    localparam int PW    = 32;
    localparam int ACC_W = 32;
    localparam int CNT_W = 8;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PW-1:0]    in_prod = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    exp_t sb[$];
    int   hs_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;

    loba_prod_accumulator #(.PW(PW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_acc", 64'(out_acc), 64'(mon_e.acc));
                chk("out_cnt", 64'(out_cnt), 64'(mon_e.cnt));
                chk("out_ovf", 64'(out_ovf), 64'(mon_e.ovf));
            end
        end
    end

    task automatic expect_res(input logic [ACC_W-1:0] a, input logic [CNT_W-1:0] c, input logic o);
        exp_t e;
        e.acc = a;
        e.cnt = c;
        e.ovf = o;
        sb.push_back(e);
    endtask

    // Present one beat and hold it until accepted; leaves in_valid high afterwards.
    task automatic send(input logic [PW-1:0] p, input logic l);
        int n;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (l) chk("latency_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_acc", 64'(out_acc), 64'd0);
        chk("rst_cnt", 64'(out_cnt), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 100 + 200 + 300
        out_ready = 1'b1;
        expect_res(32'd600, 8'd3, 1'b0);
        send(32'd100, 1'b0);
        send(32'd200, 1'b0);
        send(32'd300, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Single-beat group of the largest product
        expect_res(32'hFFFF_FFFF, 8'd1, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back single-beat groups, no bubbles
        hs_cyc.delete();
        expect_res(32'd5, 8'd1, 1'b0);
        expect_res(32'd7, 8'd1, 1'b0);
        expect_res(32'd9, 8'd1, 1'b0);
        send(32'd5, 1'b1);
        send(32'd7, 1'b1);
        send(32'd9, 1'b1);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_count", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) begin
            chk("b2b_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
            chk("b2b_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd1);
        end

        // Backpressure: result 42 held while a pending beat waits
        out_ready = 1'b0;
        expect_res(32'd42, 8'd1, 1'b0);
        send(32'd42, 1'b1);
        in_valid = 1'b1;
        in_prod  = 32'd11;
        in_last  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_out_acc", 64'(out_acc), 64'd42);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'd11, 1'b0);
        expect_res(32'd15, 8'd2, 1'b0);
        send(32'd4, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Carry out of ACC_W
`ifdef LOBA_ACC_SAT_EN
        expect_res(32'hFFFF_FFFF, 8'd2, 1'b1);
`else
        expect_res(32'd1, 8'd2, 1'b1);
`endif
        send(32'hFFFF_FFFF, 1'b0);
        send(32'd2, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-group
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        chk("midrst_acc", 64'(out_acc), 64'd0);
        chk("midrst_cnt", 64'(out_cnt), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        expect_res(32'd3, 8'd1, 1'b0);
        send(32'd3, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset while holding a result discards it
        out_ready = 1'b0;
        send(32'd50, 1'b1);
        idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("donerst_out_valid", 64'(out_valid), 64'd0);
        chk("donerst_acc", 64'(out_acc), 64'd0);
        chk("donerst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Count saturation: 300 beats of 1
        expect_res(32'd300, 8'd255, 1'b0);
        for (int i = 0; i < 299; i++) send(32'd1, 1'b0);
        send(32'd1, 1'b1);
        idle();

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
